// File: rtl/if_row_feeder_pkg.sv
// if_feeder_pkg: shared definitions for the IF row feeder.
//   - IF_SCRATCH_WIDTH : data bits per ifmap word
//   - CNT_W            : width of the row-length / row-count configuration
//   - TAG_W, SOR_BIT, EOR_BIT : layout of the tagged IF buffer word {sor, eor, data}
//   - state_t          : feeder FSM states
package if_feeder_pkg;

  localparam int IF_SCRATCH_WIDTH = 16;
  localparam int CNT_W            = 8;
  localparam int TAG_W            = 2;
  localparam int SOR_BIT          = IF_SCRATCH_WIDTH + 1;
  localparam int EOR_BIT          = IF_SCRATCH_WIDTH;
  localparam int STALL_W          = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/if_row_feeder_if.sv
// if_row_feeder_if: upstream word stream into the feeder (valid/ready).
//   s_valid : upstream word valid       (master -> slave)
//   s_data  : upstream ifmap word       (master -> slave)
//   s_ready : feeder accepts this cycle (slave -> master)
interface if_row_feeder_if #(
  parameter int DATA_W = if_feeder_pkg::IF_SCRATCH_WIDTH
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/if_row_feeder.sv
// if_row_feeder: frames a plain ifmap word stream into rows and writes
// {sor, eor, data} tagged words into the IF input FIFO.
//
// Ports:
//   clk, rst            : clock (rising edge), async active-low reset
//   start               : one-cycle frame start, latches row_len/num_rows
//   row_len, num_rows   : frame geometry (words per row, rows per frame)
//   s                   : upstream valid/ready word stream (slave side)
//   IF_full             : IF buffer full
//   IF_wen, IF_din      : IF buffer write port, combinational pass-through
//   busy, done, cfg_err : status (done / cfg_err are one-cycle pulses)
//   stall_cnt           : cycles the stream stalled on IF_full
//
// Build option: define IF_FEEDER_STATS_EN to build the saturating stall
// counter; otherwise stall_cnt is tied to zero.
//
// state  | meaning
// IDLE   | waiting for a valid start
// STREAM | passing words through, counting col/row
// DONE   | one-cycle done pulse after the final word
module if_row_feeder
  import if_feeder_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [CNT_W-1:0]                    row_len,
  input  logic [CNT_W-1:0]                    num_rows,
  if_row_feeder_if.slave                      s,
  input  logic                                IF_full,
  output logic                                IF_wen,
  output logic [IF_SCRATCH_WIDTH+TAG_W-1:0]   IF_din,
  output logic                                busy,
  output logic                                done,
  output logic                                cfg_err,
  output logic [STALL_W-1:0]                  stall_cnt
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, rows_q, col_q, row_q;
  logic             cfg_ok, accept_start, ready, xfer, last_col, last_row;

  assign cfg_ok       = (row_len != '0) && (num_rows != '0);
  assign accept_start = (state_q == IDLE) && start && cfg_ok;

  assign ready    = (state_q == STREAM) && !IF_full;
  assign xfer     = s.s_valid && ready;
  // len_q/rows_q are never zero outside IDLE, so the subtraction cannot wrap.
  assign last_col = (col_q == len_q - CNT_W'(1));
  assign last_row = (row_q == rows_q - CNT_W'(1));

  assign s.s_ready = ready;
  assign IF_wen    = xfer;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cfg_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) state_d = STREAM;
          else        cfg_err = 1'b1;
        end
      end
      STREAM: begin
        if (xfer && last_col && last_row) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q  <= '0;
      rows_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else if (accept_start) begin
      len_q  <= row_len;
      rows_q <= num_rows;
      col_q  <= '0;
      row_q  <= '0;
    end else if (xfer) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= row_q + CNT_W'(1);
      end else begin
        col_q <= col_q + CNT_W'(1);
      end
    end
  end

  // Data is gated by the write so IF_din reads as zero whenever nothing is
  // being written, including during reset.
  always_comb begin
    IF_din = '0;
    if (xfer) begin
      IF_din[SOR_BIT]                = (col_q == '0);
      IF_din[EOR_BIT]                = last_col;
      IF_din[IF_SCRATCH_WIDTH-1:0]   = s.s_data;
    end
  end

`ifdef IF_FEEDER_STATS_EN
  logic [STALL_W-1:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (accept_start) begin
      stall_q <= '0;
    end else if ((state_q == STREAM) && s.s_valid && IF_full && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_if_row_feeder.sv
module tb_if_row_feeder;
  import if_feeder_pkg::*;

  logic                              clk;
  logic                              rst;
  logic                              start;
  logic [CNT_W-1:0]                  row_len;
  logic [CNT_W-1:0]                  num_rows;
  logic                              IF_full;
  logic                              IF_wen;
  logic [IF_SCRATCH_WIDTH+TAG_W-1:0] IF_din;
  logic                              busy;
  logic                              done;
  logic                              cfg_err;
  logic [STALL_W-1:0]                stall_cnt;

  if_row_feeder_if #(.DATA_W(IF_SCRATCH_WIDTH)) s_if ();

  if_row_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .row_len   (row_len),
    .num_rows  (num_rows),
    .s         (s_if),
    .IF_full   (IF_full),
    .IF_wen    (IF_wen),
    .IF_din    (IF_din),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int        checks = 0;
  int        errors = 0;
  logic [17:0] exp_q[$];
  logic [15:0] data_src[$];
  bit          full_sched[$];
  int          model_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every IF write must match the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && IF_full) begin
        check("wen_while_full", {31'd0, IF_wen}, 32'd0);
        check("ready_while_full", {31'd0, s_if.s_ready}, 32'd0);
      end
      if (IF_wen) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {14'd0, IF_din}, 32'hFFFF_FFFF);
        end else begin
          check("if_din", {14'd0, IF_din}, {14'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs one frame: issues start, streams words, pushes expectations.
  // Returns early (aborted=1) once abort_after words were accepted.
  task automatic run_frame(input int L, input int R, input int pv, input int pf,
                           input int restart_at, input int abort_after,
                           output bit aborted);
    int issued, accepted, total, cyc;
    bit x;
    logic [15:0] d;
    aborted  = 1'b0;
    start    = 1'b1;
    row_len  = CNT_W'(L);
    num_rows = CNT_W'(R);
    @(posedge clk); #1;
    start = 1'b0;
    model_stall = 0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    issued = 0; accepted = 0; total = L * R; cyc = 0;
    forever begin
      if (cyc == restart_at) begin
        start    = 1'b1;
        row_len  = CNT_W'(L + 2);
        num_rows = CNT_W'(R + 1);
      end else begin
        start = 1'b0;
      end
      if (!s_if.s_valid && issued < total && $urandom_range(99) < pv) begin
        d = (data_src.size() > 0) ? data_src.pop_front() : 16'($urandom);
        s_if.s_valid = 1'b1;
        s_if.s_data  = d;
        exp_q.push_back({((issued % L) == 0), ((issued % L) == L - 1), d});
        issued++;
      end
      IF_full = (full_sched.size() > 0) ? full_sched.pop_front() : ($urandom_range(99) < pf);
      @(negedge clk);
      x = s_if.s_valid && s_if.s_ready;
      if (s_if.s_valid && IF_full) model_stall++;
      @(posedge clk); #1;
      cyc++;
      if (x) begin
        s_if.s_valid = 1'b0;
        accepted++;
      end
      if (accepted == total) break;
      if (abort_after > 0 && accepted == abort_after) begin
        aborted = 1'b1;
        break;
      end
      if (cyc > 3000) begin
        check("frame_cycle_budget", cyc, 32'd3000);
        aborted = 1'b1;
        break;
      end
    end
    start   = 1'b0;
    IF_full = 1'b0;
    if (!aborted) begin
      check("done_pulse", {31'd0, done}, 32'd1);
      check("busy_in_done", {31'd0, busy}, 32'd1);
      check("queue_drained", exp_q.size(), 32'd0);
`ifdef IF_FEEDER_STATS_EN
      check("stall_cnt", {16'd0, stall_cnt}, model_stall);
`else
      check("stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
      @(posedge clk); #1;
      check("done_low_after", {31'd0, done}, 32'd0);
      check("busy_low_after", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    bit ab;
    rst = 1'b0; start = 1'b0; row_len = '0; num_rows = '0; IF_full = 1'b0;
    s_if.s_valid = 1'b0; s_if.s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", {31'd0, s_if.s_ready}, 32'd0);
    check("rst_wen", {31'd0, IF_wen}, 32'd0);
    check("rst_din", {14'd0, IF_din}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    check("rst_stall", {16'd0, stall_cnt}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Basic frame: 4x2, data 1..8, valid always high, no backpressure.
    for (int i = 1; i <= 8; i++) data_src.push_back(16'(i));
    run_frame(4, 2, 100, 0, -1, 0, ab);

    // Backpressure: full for 5 cycles after the second word.
    full_sched = '{0, 0, 1, 1, 1, 1, 1};
    run_frame(4, 1, 100, 0, -1, 0, ab);

    // Single-word rows.
    data_src = '{16'hFFF7, 16'h0029, 16'hFFD3};
    run_frame(1, 3, 100, 0, -1, 0, ab);

    // Bad configurations.
    start = 1'b1; row_len = 8'd0; num_rows = 8'd3; #1;
    check("cfg_err_len0", {31'd0, cfg_err}, 32'd1);
    @(posedge clk); #1; start = 1'b0; #1;
    check("cfg_err_clear", {31'd0, cfg_err}, 32'd0);
    check("busy_after_bad", {31'd0, busy}, 32'd0);
    start = 1'b1; row_len = 8'd2; num_rows = 8'd0; #1;
    check("cfg_err_rows0", {31'd0, cfg_err}, 32'd1);
    @(posedge clk); #1; start = 1'b0;
    check("busy_after_bad2", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // Restart while busy: the second start must be ignored.
    run_frame(3, 2, 80, 20, 2, 0, ab);

    // Randomized frames.
    for (int f = 0; f < 8; f++) begin
      run_frame($urandom_range(6, 1), $urandom_range(4, 1), $urandom_range(100, 40),
                $urandom_range(40, 0), -1, 0, ab);
    end

    // Reset mid-frame after 3 of 8 words.
    run_frame(4, 2, 100, 0, -1, 3, ab);
    rst = 1'b0; #1;
    check("midrst_wen", {31'd0, IF_wen}, 32'd0);
    check("midrst_ready", {31'd0, s_if.s_ready}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_din", {14'd0, IF_din}, 32'd0);
    check("midrst_stall", {16'd0, stall_cnt}, 32'd0);
    s_if.s_valid = 1'b0;
    exp_q.delete();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    run_frame(2, 2, 100, 0, -1, 0, ab);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
